dphy_lane_sync_hunter: RTL and testbench

Per-lane HS front end running at DDR bit rate on dphy_clk. It takes the 2-bit DDR sample pair from one lane's LVDS input register and hunts for the D-PHY HS sync byte (0xB8) at either bit phase. Once found, it locks the phase and emits one aligned data byte every 4 dphy_clk cycles. It sits between the lane SB_IO input registers and the word-rate packet logic, replacing separate deserialise and align stages with a single bit-rate stage.

---
 rtl/dphy_pkg.sv | 12 +
 rtl/dphy_lane_sync_hunter.sv | 122 ++++++++++++
 tb/tb_dphy_lane_sync_hunter.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dphy_pkg.sv
// Shared D-PHY definitions: HS leader sync byte and the lane sync-hunter state encoding.
package dphy_pkg;

  localparam logic [7:0] HS_SYNC_BYTE = 8'hB8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HUNT   = 2'd1,
    LOCKED = 2'd2
  } hunter_state_e;

endpackage

// File: rtl/dphy_lane_sync_hunter.sv
// Bit-rate HS front end for one D-PHY lane: hunts the sync byte at either DDR bit phase,
// then emits one aligned byte every four dphy_clk cycles until the packet ends.
module dphy_lane_sync_hunter
  import dphy_pkg::*;
#(
  parameter logic        INVERT    = 1'b0,
  parameter logic [7:0]  SYNC_BYTE = HS_SYNC_BYTE,
  parameter logic [15:0] MAX_BYTES = 16'd8192
) (
  input  logic       dphy_clk,
  input  logic       areset,
  input  logic [1:0] din,
  input  logic       hunt_en,
  input  logic       lp_active,
  input  logic       packet_done,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       sync_found,
  output logic       locked,
  output logic       bit_off,
  output logic       timeout
);

  hunter_state_e state_q, state_d;
  logic [9:0]    sr_q, sr_d;
  logic [1:0]    ph_q, ph_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          bit_off_q, bit_off_d;
  logic [7:0]    byte_q, byte_d;
  logic          valid_q, valid_d;
  logic          sync_q, sync_d;
  logic          tmo_q, tmo_d;

  logic [1:0]    d;
  logic          m0, m1;
  logic [7:0]    win;
  logic [15:0]   cnt_inc;

  assign d       = INVERT ? ~din : din;
  // Newest pair enters at the top so LSB-first bytes read out as sr[k+7:k].
  assign sr_d    = {d[0], d[1], sr_q[9:2]};
  assign m0      = (sr_q[7:0] == SYNC_BYTE);
  assign m1      = (sr_q[8:1] == SYNC_BYTE);
  assign win     = bit_off_q ? sr_q[8:1] : sr_q[7:0];
  assign cnt_inc = cnt_q + 16'd1;

  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q + 2'd1;
    cnt_d     = cnt_q;
    bit_off_d = bit_off_q;
    byte_d    = byte_q;
    valid_d   = 1'b0;
    sync_d    = 1'b0;
    tmo_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (hunt_en && !lp_active) state_d = HUNT;
      end
      HUNT: begin
        if (!hunt_en || lp_active) begin
          state_d = IDLE;
        end else if (m0 || m1) begin
          state_d   = LOCKED;
          bit_off_d = m1 && !m0;
          ph_d      = 2'd0;
          cnt_d     = 16'd0;
          sync_d    = 1'b1;
        end
      end
      LOCKED: begin
        // Leaving the HS burst outranks both packet end and the byte-count timeout.
        if (!hunt_en || lp_active) begin
          state_d = IDLE;
        end else if (packet_done) begin
          state_d = HUNT;
        end else if (ph_q == 2'd3) begin
          byte_d  = win;
          valid_d = 1'b1;
          cnt_d   = cnt_inc;
          if (cnt_inc == MAX_BYTES) begin
            tmo_d   = 1'b1;
            state_d = HUNT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge dphy_clk or posedge areset) begin
    if (areset) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      ph_q      <= '0;
      cnt_q     <= '0;
      bit_off_q <= 1'b0;
      byte_q    <= '0;
      valid_q   <= 1'b0;
      sync_q    <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      ph_q      <= ph_d;
      cnt_q     <= cnt_d;
      bit_off_q <= bit_off_d;
      byte_q    <= byte_d;
      valid_q   <= valid_d;
      sync_q    <= sync_d;
      tmo_q     <= tmo_d;
    end
  end

  assign byte_out   = byte_q;
  assign byte_valid = valid_q;
  assign sync_found = sync_q;
  assign locked     = (state_q == LOCKED);
  assign bit_off    = bit_off_q;
  assign timeout    = tmo_q;

endmodule

// File: tb/tb_dphy_lane_sync_hunter.sv
// Directed bench for dphy_lane_sync_hunter: default, inverted-lane and short-timeout instances
// share one bit stream; events are logged per edge and checked with immediate assertions.
module tb_dphy_lane_sync_hunter;

  logic       clk = 1'b0;
  logic       areset;
  logic [1:0] din;
  logic [1:0] din_inv;
  logic       hunt_en, lp_active, packet_done;

  logic [7:0] bo_a, bo_i, bo_t;
  logic       bv_a, bv_i, bv_t;
  logic       sf_a, sf_i, sf_t;
  logic       lk_a, lk_i, lk_t;
  logic       off_a, off_i, off_t;
  logic       to_a, to_i, to_t;

  int n_cmp = 0;
  int n_bad = 0;
  int edge_n;

  bit         bq[$];
  logic [7:0] vb_a[$], vb_i[$], vb_t[$];
  int         vi_a[$], vi_i[$], vi_t[$];
  int         sc_a, si_a, sc_i, si_i, tmo_cnt, tmo_idx, tmo_a_cnt;

  assign din_inv = ~din;

  always #5 clk = ~clk;

  dphy_lane_sync_hunter dut_a (
    .dphy_clk(clk), .areset(areset), .din(din), .hunt_en(hunt_en),
    .lp_active(lp_active), .packet_done(packet_done),
    .byte_out(bo_a), .byte_valid(bv_a), .sync_found(sf_a),
    .locked(lk_a), .bit_off(off_a), .timeout(to_a)
  );

  dphy_lane_sync_hunter #(.INVERT(1'b1)) dut_i (
    .dphy_clk(clk), .areset(areset), .din(din_inv), .hunt_en(hunt_en),
    .lp_active(lp_active), .packet_done(packet_done),
    .byte_out(bo_i), .byte_valid(bv_i), .sync_found(sf_i),
    .locked(lk_i), .bit_off(off_i), .timeout(to_i)
  );

  dphy_lane_sync_hunter #(.MAX_BYTES(16'd4)) dut_t (
    .dphy_clk(clk), .areset(areset), .din(din), .hunt_en(hunt_en),
    .lp_active(lp_active), .packet_done(packet_done),
    .byte_out(bo_t), .byte_valid(bv_t), .sync_found(sf_t),
    .locked(lk_t), .bit_off(off_t), .timeout(to_t)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    vb_a.delete(); vb_i.delete(); vb_t.delete();
    vi_a.delete(); vi_i.delete(); vi_t.delete();
    bq.delete();
    sc_a = 0; si_a = -1; sc_i = 0; si_i = -1;
    tmo_cnt = 0; tmo_idx = -1; tmo_a_cnt = 0;
    edge_n = 0;
  endtask

  task automatic do_reset();
    areset      = 1'b1;
    din         = 2'b00;
    packet_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    areset = 1'b0;
    clear_log();
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int k = 0; k < 8; k++) bq.push_back(b[k]);
  endtask

  task automatic push_zeros(input int n);
    for (int k = 0; k < n; k++) bq.push_back(1'b0);
  endtask

  // One edge: earlier wire bit on din[1], later on din[0]; outputs logged 1 ns after the edge.
  task automatic tick(input logic pd);
    logic [1:0] p;
    p = 2'b00;
    if (bq.size() > 0) p[1] = bq.pop_front();
    if (bq.size() > 0) p[0] = bq.pop_front();
    din         = p;
    packet_done = pd;
    @(posedge clk);
    #1;
    packet_done = 1'b0;
    edge_n++;
    if (bv_a) begin
      vb_a.push_back(bo_a); vi_a.push_back(edge_n);
      $display("edge %0d: dut_a byte %02h", edge_n, bo_a);
    end
    if (bv_i) begin vb_i.push_back(bo_i); vi_i.push_back(edge_n); end
    if (bv_t) begin vb_t.push_back(bo_t); vi_t.push_back(edge_n); end
    if (sf_a) begin sc_a++; si_a = edge_n; $display("edge %0d: dut_a sync bit_off=%0d", edge_n, off_a); end
    if (sf_i) begin sc_i++; si_i = edge_n; end
    if (to_t) begin tmo_cnt++; tmo_idx = edge_n; end
    if (to_a) tmo_a_cnt++;
  endtask

  task automatic run_all();
    while (bq.size() > 0) tick(1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed time limit expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    hunt_en     = 1'b1;
    lp_active   = 1'b0;
    packet_done = 1'b0;
    din         = 2'b00;
    areset      = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_byte_out",   {24'd0, bo_a}, 32'h00);
    check("rst_byte_valid", {31'd0, bv_a}, 32'h0);
    check("rst_sync_found", {31'd0, sf_a}, 32'h0);
    check("rst_locked",     {31'd0, lk_a}, 32'h0);
    check("rst_bit_off",    {31'd0, off_a}, 32'h0);
    check("rst_timeout",    {31'd0, to_a}, 32'h0);
    check("rst_all_inv",    {18'd0, bo_i, bv_i, sf_i, lk_i, off_i, to_i}, 32'h0);
    check("rst_all_tmo",    {18'd0, bo_t, bv_t, sf_t, lk_t, off_t, to_t}, 32'h0);

    // Phase 0: detection 2 pairs after the sync byte ends (edge 14), captures at 18, 22, 26, 30.
    // byte_valid logged at edge 18 is seen by a consumer on edge 19, five edges after detection.
    do_reset();
    push_zeros(16); push_byte(8'hB8); push_byte(8'h12); push_byte(8'h34); push_zeros(24);
    run_all();
    check("p0_sync_count", sc_a, 1);
    check("p0_sync_edge",  si_a, 14);
    check("p0_bit_off",    {31'd0, off_a}, 32'h0);
    check("p0_locked",     {31'd0, lk_a}, 32'h1);
    check("p0_valid_count", vb_a.size(), 4);
    if (vb_a.size() >= 2) begin
      check("p0_byte0", {24'd0, vb_a[0]}, 32'h12);
      check("p0_edge0", vi_a[0], 18);
      check("p0_byte1", {24'd0, vb_a[1]}, 32'h34);
      check("p0_edge1", vi_a[1], 22);
    end
    check("inv_sync_edge",   si_i, 14);
    check("inv_sync_count",  sc_i, 1);
    check("inv_bit_off",     {31'd0, off_i}, 32'h0);
    check("inv_valid_count", vb_i.size(), 4);
    if (vb_i.size() >= 2) begin
      check("inv_byte0", {24'd0, vb_i[0]}, 32'h12);
      check("inv_byte1", {24'd0, vb_i[1]}, 32'h34);
      check("inv_edge1", vi_i[1], 22);
    end

    // Phase 1: one extra leading zero bit puts the sync at odd bit offset; timing is unchanged.
    do_reset();
    push_zeros(17); push_byte(8'hB8); push_byte(8'h12); push_byte(8'h34); push_zeros(23);
    run_all();
    check("p1_sync_edge", si_a, 14);
    check("p1_bit_off",   {31'd0, off_a}, 32'h1);
    check("p1_inv_bit_off", {31'd0, off_i}, 32'h1);
    check("p1_valid_count", vb_a.size(), 4);
    if (vb_a.size() >= 2) begin
      check("p1_byte0", {24'd0, vb_a[0]}, 32'h12);
      check("p1_edge0", vi_a[0], 18);
      check("p1_byte1", {24'd0, vb_a[1]}, 32'h34);
    end

    // packet_done on the first capture edge (edge 18) suppresses the byte and returns to hunt.
    do_reset();
    push_zeros(16); push_byte(8'hB8); push_byte(8'h12); push_byte(8'h12); push_byte(8'h12);
    repeat (14) tick(1'b0);
    check("pd_sync_edge", si_a, 14);
    repeat (3) tick(1'b0);
    tick(1'b1);
    check("pd_no_valid",  {31'd0, bv_a}, 32'h0);
    check("pd_locked",    {31'd0, lk_a}, 32'h0);
    run_all();
    check("pd_valid_count", vb_a.size(), 0);
    push_zeros(8); push_byte(8'hB8); push_zeros(16);
    run_all();
    check("pd_relock_sync", sc_a, 2);
    check("pd_relock_locked", {31'd0, lk_a}, 32'h1);

    // MAX_BYTES=4: captures at 18, 22, 26, 30; the 4th byte and the timeout pulse share edge 30.
    do_reset();
    push_zeros(16); push_byte(8'hB8);
    for (int k = 0; k < 8; k++) push_byte(8'hAA);
    run_all();
    check("to_valid_count", vb_t.size(), 4);
    if (vb_t.size() == 4) begin
      check("to_byte0", {24'd0, vb_t[0]}, 32'hAA);
      check("to_byte1", {24'd0, vb_t[1]}, 32'hAA);
      check("to_byte2", {24'd0, vb_t[2]}, 32'hAA);
      check("to_byte3", {24'd0, vb_t[3]}, 32'hAA);
      check("to_last_edge", vi_t[3], 30);
    end
    check("to_pulse_count", tmo_cnt, 1);
    check("to_pulse_edge",  tmo_idx, 30);
    check("to_locked",      {31'd0, lk_t}, 32'h0);
    check("to_default_none", tmo_a_cnt, 0);
    check("to_default_locked", {31'd0, lk_a}, 32'h1);

    // lp_active mid-packet: unlock on the next edge, sync ignored until lp_active falls.
    do_reset();
    push_zeros(16); push_byte(8'hB8); push_byte(8'h12); push_byte(8'h12);
    repeat (18) tick(1'b0);
    check("lp_first_count", vb_a.size(), 1);
    lp_active = 1'b1;
    tick(1'b0);
    check("lp_locked_drop", {31'd0, lk_a}, 32'h0);
    push_byte(8'hB8); push_byte(8'h12); push_byte(8'h12); push_zeros(8);
    run_all();
    check("lp_valid_count", vb_a.size(), 1);
    check("lp_sync_ignored", sc_a, 1);
    check("lp_still_unlocked", {31'd0, lk_a}, 32'h0);
    lp_active = 1'b0;
    push_zeros(8); push_byte(8'hB8); push_zeros(16);
    run_all();
    check("lp_relock_sync", sc_a, 2);
    check("lp_relock_locked", {31'd0, lk_a}, 32'h1);

    // areset mid-packet: outputs clear immediately and nothing further is emitted.
    do_reset();
    push_zeros(16); push_byte(8'hB8); push_byte(8'h34); push_byte(8'h34); push_byte(8'h34);
    repeat (19) tick(1'b0);
    check("ar_locked_before", {31'd0, lk_a}, 32'h1);
    check("ar_first_count",   vb_a.size(), 1);
    #2;
    areset = 1'b1;
    #1;
    check("ar_locked_now",  {31'd0, lk_a}, 32'h0);
    check("ar_byte_out",    {24'd0, bo_a}, 32'h00);
    check("ar_byte_valid",  {31'd0, bv_a}, 32'h0);
    tick(1'b0);
    tick(1'b0);
    areset = 1'b0;
    run_all();
    check("ar_valid_count", vb_a.size(), 1);
    check("ar_unlocked",    {31'd0, lk_a}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
